// File: rtl/mp_control_fsm_pkg.sv
// Shared definitions for the microprocessor control sequencer: opcodes, FSM
// state encodings, write-back select values and the Moore control decode.
package mp_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_STORE  = 2'b10,
        OP_BRANCH = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_e;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    typedef struct packed {
        logic imem_req;
        logic ir_load;
        logic pc_inc;
        logic pc_branch;
        logic reg_write;
        logic wb_sel;
        logic mem_read;
        logic mem_write;
    } ctl_t;

    // Every strobe is a pure function of registered state and latched opcode.
    // LOAD/STORE retire their register/PC effects in WB, after the data ack.
    function automatic ctl_t decode_ctl(state_e st, op_e op);
        ctl_t c;
        c = '0;
        case (st)
            S_FETCH:  c.imem_req = 1'b1;
            S_DECODE: c.ir_load  = 1'b1;
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_ALU;
                        c.pc_inc    = 1'b1;
                    end
                    OP_BRANCH: c.pc_branch = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                c.mem_read  = (op == OP_LOAD);
                c.mem_write = (op == OP_STORE);
            end
            S_WB: begin
                case (op)
                    OP_LOAD: begin
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_MEM;
                        c.pc_inc    = 1'b1;
                    end
                    OP_STORE: c.pc_inc = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mp_control_fsm_if.sv
// Instruction- and data-memory handshake bundle between sequencer and memories.
interface mp_control_fsm_if;
    logic       imem_req;
    logic [7:0] instruction;
    logic       imem_ack;
    logic       mem_read;
    logic       mem_write;
    logic       dmem_ack;

    modport master (
        output imem_req, mem_read, mem_write,
        input  instruction, imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, mem_read, mem_write,
        output instruction, imem_ack, dmem_ack
    );
endinterface

// File: rtl/mp_control_fsm_ack_timer.sv
// Handshake watchdog: reloads while not waiting, counts down while waiting,
// flags expiry once ACK_TIMEOUT waiting cycles have elapsed.
module mp_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic oscillator,
    input  logic reset,
    input  logic load,
    output logic expired
);
    localparam int            W     = $clog2(ACK_TIMEOUT);
    localparam logic [W-1:0]  START = W'(ACK_TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge oscillator or posedge reset) begin
        if (reset)
            cnt <= START;
        else if (load)
            cnt <= START;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Reaches zero in the ACK_TIMEOUT-th waiting cycle.
    assign expired = (cnt == '0) && !load;

endmodule

// File: rtl/mp_control_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/write-back with
// run/step control, handshake timeout to a sticky FAULT state, retire counter.
module mp_control_fsm
    import mp_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               oscillator,
    input  logic               reset,
    input  logic               tick,
    input  logic               run,
    input  logic               step,
    mp_control_fsm_if.master   bus,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_branch,
    output logic               reg_write,
    output logic               wb_sel,
    output logic [2:0]         state,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);
    state_e state_q, state_d;
    op_e    op_q;
    ctl_t   ctl;
    logic   timer_load, expired;

    // Timer holds its start value outside the two wait states, so it is
    // fresh on every entry to FETCH or MEM.
    assign timer_load = !(state_q == S_FETCH || state_q == S_MEM);

    mp_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .oscillator (oscillator),
        .reset      (reset),
        .load       (timer_load),
        .expired    (expired)
    );

    always_ff @(posedge oscillator or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && bus.imem_ack)
                op_q <= op_e'(bus.instruction[7:6]);
            if (state_q == S_WB)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run ? tick : step) state_d = S_FETCH;
            // Ack is checked first so an ack in the expiry cycle still succeeds.
            S_FETCH: begin
                if (bus.imem_ack)  state_d = S_DECODE;
                else if (expired)  state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.dmem_ack)  state_d = S_WB;
                else if (expired)  state_d = S_FAULT;
            end
            S_WB:     state_d = S_IDLE;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    assign ctl = decode_ctl(state_q, op_q);

    assign bus.imem_req  = ctl.imem_req;
    assign bus.mem_read  = ctl.mem_read;
    assign bus.mem_write = ctl.mem_write;
    assign ir_load       = ctl.ir_load;
    assign pc_inc        = ctl.pc_inc;
    assign pc_branch     = ctl.pc_branch;
    assign reg_write     = ctl.reg_write;
    assign wb_sel        = ctl.wb_sel;

    assign state  = state_q;
    assign halted = (state_q == S_IDLE) && !run;
    assign fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_mp_control_fsm.sv
// Directed bench for mp_control_fsm: hand-computed strobe counts, latencies,
// timeout and reset behaviour, checked through one comparison task.
module tb_mp_control_fsm;

    logic        oscillator = 1'b0;
    logic        reset      = 1'b1;
    logic        tick       = 1'b0;
    logic        run        = 1'b0;
    logic        step       = 1'b0;
    logic        ir_load, pc_inc, pc_branch, reg_write, wb_sel, halted, fault;
    logic [2:0]  state;
    logic [15:0] retired;

    mp_control_fsm_if bus ();

    mp_control_fsm #(.ACK_TIMEOUT(16), .CNT_W(16)) dut (
        .oscillator (oscillator),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .step       (step),
        .bus        (bus),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .state      (state),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 oscillator = ~oscillator;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic tick_en = 1'b0;

    always @(posedge oscillator) cyc <= cyc + 1;

    // Divider model: one-cycle tick every 4th cycle while enabled.
    initial forever begin
        @(posedge oscillator);
        #1;
        tick = tick_en && (cyc % 4 == 0);
    end

    // Running totals of strobe activity, sampled mid-cycle.
    localparam int M_IR = 0, M_INC = 1, M_BR = 2, M_RW = 3, M_MRD = 4,
                   M_MWR = 5, M_BUSY = 6, M_RWINC = 7, M_BAD = 8;
    int   tot  [9] = '{default: 0};
    int   base [9] = '{default: 0};
    logic last_wbsel = 1'bx;

    always @(negedge oscillator) begin
        if (ir_load)                tot[M_IR]    <= tot[M_IR] + 1;
        if (pc_inc)                 tot[M_INC]   <= tot[M_INC] + 1;
        if (pc_branch)              tot[M_BR]    <= tot[M_BR] + 1;
        if (bus.mem_read)           tot[M_MRD]   <= tot[M_MRD] + 1;
        if (bus.mem_write)          tot[M_MWR]   <= tot[M_MWR] + 1;
        if (state != 3'd0)          tot[M_BUSY]  <= tot[M_BUSY] + 1;
        if (reg_write && pc_inc)    tot[M_RWINC] <= tot[M_RWINC] + 1;
        if ((pc_inc && pc_branch) || (bus.mem_read && bus.mem_write))
                                    tot[M_BAD]   <= tot[M_BAD] + 1;
        if (reg_write) begin
            tot[M_RW]  <= tot[M_RW] + 1;
            last_wbsel <= wb_sel;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int d(input int i);
        return tot[i] - base[i];
    endfunction

    task automatic snap();
        base = tot;
    endtask

    task automatic nxt();
        @(posedge oscillator);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        nxt();
        step = 1'b0;
    endtask

    // Memory responder: imem ack after iwait extra FETCH cycles; dmem ack in
    // the dwait-th MEM cycle (dwait < 0: never ack, wait for FAULT).
    task automatic do_instr(input logic [7:0] ins, input int iwait, input int dwait);
        int t;
        t = 0;
        while (!bus.imem_req && t < 50) begin nxt(); t++; end
        check("imem_req_seen", int'(bus.imem_req), 1);
        if (!bus.imem_req) return;
        repeat (iwait) nxt();
        bus.instruction = ins;
        bus.imem_ack    = 1'b1;
        nxt();
        bus.imem_ack    = 1'b0;
        bus.instruction = 8'h00;
        run             = 1'b0;
        if (ins[7:6] == 2'b01 || ins[7:6] == 2'b10) begin
            t = 0;
            while (!(bus.mem_read || bus.mem_write) && t < 10) begin nxt(); t++; end
            check("mem_req_seen", int'(bus.mem_read || bus.mem_write), 1);
            if (dwait < 0) begin
                t = 0;
                while (state != 3'd7 && t < 40) begin nxt(); t++; end
                return;
            end
            repeat (dwait - 1) nxt();
            bus.dmem_ack = 1'b1;
            nxt();
            bus.dmem_ack = 1'b0;
        end
        t = 0;
        while (state != 3'd0 && t < 50) begin nxt(); t++; end
        check("back_to_idle", int'(state), 0);
    endtask

    initial begin
        bus.instruction = 8'h00;
        bus.imem_ack    = 1'b0;
        bus.dmem_ack    = 1'b0;
        nxt();
        nxt();
        reset = 1'b0;
        nxt();

        // Reset state
        check("rst_state",   int'(state), 0);
        check("rst_imem_req", int'(bus.imem_req), 0);
        check("rst_mem_rw",  int'(bus.mem_read || bus.mem_write), 0);
        check("rst_fault",   int'(fault), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_halted",  int'(halted), 1);
        check("rst_strobes", int'(ir_load || pc_inc || pc_branch || reg_write), 0);

        // 1: ADD, free-run on tick, ack in the second FETCH cycle
        run = 1'b1; tick_en = 1'b1;
        snap();
        do_instr(8'h1B, 1, 0);
        check("add_ir_load",   d(M_IR), 1);
        check("add_reg_write", d(M_RW), 1);
        check("add_pc_inc",    d(M_INC), 1);
        check("add_rw_inc_same", d(M_RWINC), 1);
        check("add_wb_sel",    int'(last_wbsel), 0);
        check("add_no_branch", d(M_BR), 0);
        check("add_retired",   int'(retired), 1);

        // 2: LOAD, dmem ack in third MEM cycle
        run = 1'b1;
        snap();
        do_instr(8'h52, 0, 3);
        check("load_mem_read_cycles", d(M_MRD), 3);
        check("load_no_mem_write", d(M_MWR), 0);
        check("load_reg_write", d(M_RW), 1);
        check("load_wb_sel",    int'(last_wbsel), 1);
        check("load_pc_inc",    d(M_INC), 1);
        check("load_rw_inc_same", d(M_RWINC), 1);
        check("load_retired",   int'(retired), 2);

        // 3: BRANCH, immediate ack -> minimum latency
        run = 1'b1;
        snap();
        do_instr(8'hC3, 0, 0);
        check("br_pc_branch", d(M_BR), 1);
        check("br_no_pc_inc", d(M_INC), 0);
        check("br_no_reg_write", d(M_RW), 0);
        check("br_no_mem", d(M_MRD) + d(M_MWR), 0);
        check("br_busy_cycles", d(M_BUSY), 4);
        check("br_retired", int'(retired), 3);

        // 4: halted, two steps one cycle apart -> one instruction
        run = 1'b0;
        snap();
        pulse_step();
        nxt();
        pulse_step();
        do_instr(8'h1B, 0, 0);
        repeat (6) nxt();
        check("step_one_instr", d(M_IR), 1);
        check("step_retired",   int'(retired), 4);
        check("step_idle",      int'(state), 0);
        check("step_halted",    int'(halted), 1);
        pulse_step();
        do_instr(8'h1B, 0, 0);
        check("step2_retired",  int'(retired), 5);

        // step ignored while running; tick disabled
        tick_en = 1'b0;
        nxt();
        nxt();
        run = 1'b1;
        pulse_step();
        repeat (3) nxt();
        check("step_run_ignored", int'(state), 0);
        check("run_not_halted",   int'(halted), 0);
        run = 1'b0;

        // acks with no request pending
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        nxt();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        nxt();
        check("stray_ack_state",   int'(state), 0);
        check("stray_ack_retired", int'(retired), 5);

        // 5: STORE without dmem ack -> FAULT after 16 cycles
        snap();
        pulse_step();
        do_instr(8'h90, 0, -1);
        check("to_mem_write_cycles", d(M_MWR), 16);
        check("to_fault",     int'(fault), 1);
        check("to_state",     int'(state), 7);
        check("to_mem_write_low", int'(bus.mem_write), 0);
        check("to_outputs_low", int'(bus.imem_req || pc_inc || reg_write || ir_load), 0);
        check("to_no_pc_inc", d(M_INC), 0);
        check("to_retired",   int'(retired), 5);
        pulse_step();
        nxt();
        check("fault_sticky", int'(state), 7);
        reset = 1'b1;
        #2;
        check("fault_rst_fault",   int'(fault), 0);
        check("fault_rst_state",   int'(state), 0);
        check("fault_rst_retired", int'(retired), 0);
        reset = 1'b0;
        nxt();

        // ack arriving in the expiry cycle wins
        snap();
        pulse_step();
        do_instr(8'h52, 0, 16);
        check("ackwin_fault",   int'(fault), 0);
        check("ackwin_mem_read_cycles", d(M_MRD), 16);
        check("ackwin_reg_write", d(M_RW), 1);
        check("ackwin_retired", int'(retired), 1);

        // 6: reset mid-FETCH drops the request asynchronously
        pulse_step();
        check("mid_fetch_req", int'(bus.imem_req), 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_req",     int'(bus.imem_req), 0);
        check("async_rst_state",   int'(state), 0);
        check("async_rst_retired", int'(retired), 0);
        #3;
        reset = 1'b0;
        nxt();

        check("invariants", tot[M_BAD], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
